// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for a combinational 8-bit ALU with a chaining accumulator.
// Optional divide-by-zero trap enabled by defining ALU_SEQ_DIVZERO_EN.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,  // legal range 1..15
  parameter logic [7:0]  ACC_INIT      = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic [7:0] acc_out,
  output logic [4:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_carry
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [7:0] acc_reg;
  logic       dz_reg;
  logic       rsp_valid_reg;
  logic [7:0] rsp_data_reg;
  logic       rsp_carry_reg;
  logic       rsp_err_reg;
  logic [4:0] alu_sel_reg;
  logic [7:0] alu_a_reg;
  logic [7:0] alu_b_reg;

  logic [7:0] eff_a;
  logic       div_zero;

  assign eff_a = cmd_acc ? acc_reg : cmd_a;

`ifdef ALU_SEQ_DIVZERO_EN
  assign div_zero = (cmd_op == 5'b00011) && (cmd_b == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      acc_reg       <= ACC_INIT;
      dz_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_carry_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      alu_sel_reg   <= 5'd0;
      alu_a_reg     <= 8'h00;
      alu_b_reg     <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            dz_reg <= div_zero;
            // A trapped division leaves the ALU inputs untouched and answers after one edge.
            if (div_zero) begin
              cnt_reg <= 4'd0;
            end else begin
              alu_sel_reg <= cmd_op;
              alu_a_reg   <= eff_a;
              alu_b_reg   <= cmd_b;
              cnt_reg     <= CNT_LOAD;
            end
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            if (dz_reg) begin
              rsp_data_reg  <= 8'hFF;
              rsp_carry_reg <= 1'b0;
              rsp_err_reg   <= 1'b1;
            end else begin
              rsp_data_reg  <= alu_out;
              rsp_carry_reg <= alu_carry;
              rsp_err_reg   <= 1'b0;
              acc_reg       <= alu_out;
            end
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_err   = rsp_err_reg;
  assign acc_out   = acc_reg;
  assign alu_sel   = alu_sel_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and settle 3) on a behavioural ALU,
// with a response scoreboard fed by the stimulus and drained by a monitor.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  typedef struct {
    int         inst;
    int         lat;
    logic [7:0] data;
    logic       carry;
    logic       err;
    logic [7:0] acc;
    logic [7:0] alu_a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n_v     [2];
  logic       cmd_valid_v [2];
  logic       cmd_ready_v [2];
  logic       rsp_valid_v [2];
  logic       rsp_ready_v [2];
  logic [7:0] rsp_data_v  [2];
  logic       rsp_carry_v [2];
  logic       rsp_err_v   [2];
  logic [7:0] acc_out_v   [2];
  logic [4:0] alu_sel_v   [2];
  logic [7:0] alu_a_v     [2];
  logic [7:0] alu_b_v     [2];
  logic [7:0] alu_out_v   [2];
  logic       alu_carry_v [2];
  logic [4:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_acc;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: add, sub, mul, div; 9-bit result with bit 8 as carry.
  function automatic logic [8:0] alu_f(input logic [4:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (sel)
      5'd0:    return {1'b0, a} + {1'b0, b};
      5'd1:    return {1'b0, a} - {1'b0, b};
      5'd2:    return p[8:0];
      5'd3:    return (b == 8'h00) ? 9'h000 : {1'b0, a / b};
      default: return 9'h0FF;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign {alu_carry_v[gi], alu_out_v[gi]} = alu_f(alu_sel_v[gi], alu_a_v[gi], alu_b_v[gi]);
    alu_op_sequencer #(
      .SETTLE_CYCLES((gi == 0) ? 1 : 3),
      .ACC_INIT     ((gi == 0) ? 8'h00 : 8'h5A)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_v[gi]),
      .cmd_valid(cmd_valid_v[gi]),
      .cmd_ready(cmd_ready_v[gi]),
      .cmd_op   (cmd_op),
      .cmd_a    (cmd_a),
      .cmd_b    (cmd_b),
      .cmd_acc  (cmd_acc),
      .rsp_valid(rsp_valid_v[gi]),
      .rsp_ready(rsp_ready_v[gi]),
      .rsp_data (rsp_data_v[gi]),
      .rsp_carry(rsp_carry_v[gi]),
      .rsp_err  (rsp_err_v[gi]),
      .acc_out  (acc_out_v[gi]),
      .alu_sel  (alu_sel_v[gi]),
      .alu_a    (alu_a_v[gi]),
      .alu_b    (alu_b_v[gi]),
      .alu_out  (alu_out_v[gi]),
      .alu_carry(alu_carry_v[gi])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: pop on each new response, then require the response to hold while pending.
  int   acc_cyc [2];
  logic prev_v  [2];
  exp_t cur     [2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_cyc[i] = 0;
      prev_v[i]  = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cmd_valid_v[i] && cmd_ready_v[i]) acc_cyc[i] = cyc + 1;
        if (rsp_valid_v[i] && !prev_v[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(i), 32'hFFFF);
          end else begin
            cur[i] = exp_q.pop_front();
            chk("rsp_inst",  32'(i), 32'(cur[i].inst));
            chk("latency",   32'(cyc - acc_cyc[i]), 32'(cur[i].lat));
            chk("rsp_data",  32'(rsp_data_v[i]), 32'(cur[i].data));
            chk("rsp_carry", 32'(rsp_carry_v[i]), 32'(cur[i].carry));
            chk("rsp_err",   32'(rsp_err_v[i]), 32'(cur[i].err));
            chk("acc_out",   32'(acc_out_v[i]), 32'(cur[i].acc));
            chk("alu_a",     32'(alu_a_v[i]), 32'(cur[i].alu_a));
            $display("rsp inst=%0d data=%h carry=%b err=%b acc=%h", i, rsp_data_v[i],
                     rsp_carry_v[i], rsp_err_v[i], acc_out_v[i]);
          end
        end else if (rsp_valid_v[i]) begin
          chk("hold_data",  32'(rsp_data_v[i]), 32'(cur[i].data));
          chk("hold_carry", 32'(rsp_carry_v[i]), 32'(cur[i].carry));
          chk("hold_ready", 32'(cmd_ready_v[i]), 32'd0);
        end
        prev_v[i] = rsp_valid_v[i];
      end
    end
  end

  task automatic issue(input int i, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ac, input int lat, input logic [7:0] d, input logic c,
                       input logic e, input logic [7:0] acc_e, input logic [7:0] alu_a_e,
                       input int hold);
    exp_t x;
    bit   ok;
    x.inst = i; x.lat = lat; x.data = d; x.carry = c; x.err = e; x.acc = acc_e; x.alu_a = alu_a_e;
    exp_q.push_back(x);
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = ac; cmd_valid_v[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready_v[i]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (hold == 0) cmd_valid_v[i] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid_v[i]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    rsp_ready_v[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready_v[i] = 1'b0;
    cmd_valid_v[i] = 1'b0;
  endtask

  task automatic check_idle(input int i, input logic [7:0] acc_e);
    chk("idle_ready", 32'(cmd_ready_v[i]), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid_v[i]), 32'd0);
    chk("idle_acc", 32'(acc_out_v[i]), 32'(acc_e));
    chk("idle_alu_a", 32'(alu_a_v[i]), 32'd0);
    chk("idle_alu_sel", 32'(alu_sel_v[i]), 32'd0);
    chk("idle_rsp_data", 32'(rsp_data_v[i]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; cmd_valid_v[i] = 1'b0; rsp_ready_v[i] = 1'b0;
    end
    cmd_op = 5'd0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;
    @(negedge clk);
    check_idle(0, 8'h00);
    check_idle(1, 8'h5A);

    // Settle-1 instance
    issue(0, 5'd0, 8'hF0, 8'h20, 1'b0, 1, 8'h10, 1'b1, 1'b0, 8'h10, 8'hF0, 0);
    issue(0, 5'd0, 8'h77, 8'h05, 1'b1, 1, 8'h15, 1'b0, 1'b0, 8'h15, 8'h10, 0);
    issue(0, 5'd1, 8'h05, 8'h07, 1'b0, 1, 8'hFE, 1'b1, 1'b0, 8'hFE, 8'h05, 5);
    issue(0, 5'b10101, 8'h12, 8'h34, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'h12, 0);
    issue(0, 5'd2, 8'h03, 8'h04, 1'b0, 1, 8'h0C, 1'b0, 1'b0, 8'h0C, 8'h03, 0);
    issue(0, 5'd3, 8'h09, 8'h00, 1'b0, 1, DZ ? 8'hFF : 8'h00, 1'b0, DZ,
          DZ ? 8'h0C : 8'h00, DZ ? 8'h03 : 8'h09, 0);
    issue(0, 5'd3, 8'h64, 8'h07, 1'b1, 1, DZ ? 8'h01 : 8'h00, 1'b0, 1'b0,
          DZ ? 8'h01 : 8'h00, DZ ? 8'h0C : 8'h00, 0);

    // Settle-3 instance
    issue(1, 5'd2, 8'h10, 8'h10, 1'b0, 3, 8'h00, 1'b1, 1'b0, 8'h00, 8'h10, 0);
    issue(1, 5'd3, 8'h09, 8'h00, 1'b0, DZ ? 1 : 3, DZ ? 8'hFF : 8'h00, 1'b0, DZ,
          8'h00, DZ ? 8'h10 : 8'h09, 0);
    issue(1, 5'd0, 8'h77, 8'h22, 1'b1, 3, 8'h22, 1'b0, 1'b0, 8'h22, 8'h00, 0);

    // Reset in the middle of WAIT: no response, accumulator back to its initial value
    @(posedge clk); #1;
    cmd_op = 5'd0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_acc = 1'b0; cmd_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    cmd_valid_v[1] = 1'b0;
    @(negedge clk);
    chk("wait_ready", 32'(cmd_ready_v[1]), 32'd0);
    @(posedge clk); #1;
    rst_n_v[1] = 1'b0;
    @(posedge clk); #1;
    rst_n_v[1] = 1'b1;
    @(negedge clk);
    check_idle(1, 8'h5A);
    repeat (5) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_valid_v[1]), 32'd0);
    issue(1, 5'd0, 8'h00, 8'h01, 1'b1, 3, 8'h5B, 1'b0, 1'b0, 8'h5B, 8'h5A, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
